// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared types and constants for the TDC frame transmitter
package tdc_pkg;

    localparam int CTR_WIDTH      = 11;
    // Upper bound on counters per sample; unused word slots are constant zero and get pruned.
    localparam int MAX_CTR_NUMBER = 8;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} tx_state_t;

    typedef struct packed {
        logic [7:0]                               seq;
        logic [MAX_CTR_NUMBER-1:0][CTR_WIDTH-1:0] words;
    } sample_t;

    function automatic int frame_len(input int ctr_number);
        return 3 + 2 * ctr_number;
    endfunction

endpackage

// File: rtl/tdc_sample_fifo.sv
// rtl/tdc_sample_fifo.sv - single-clock sample FIFO; write while full is taken when a read happens in the same cycle
module tdc_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd && !empty;
    assign do_wr   = wr && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tdc_frame_tx.sv
// rtl/tdc_frame_tx.sv - buffers synchronized TDC samples and sends each as a checksummed byte frame
module tdc_frame_tx
    import tdc_pkg::*;
#(
    parameter int          CTR_NUMBER = 1,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [CTR_WIDTH-1:0] in_data [CTR_NUMBER],
    input  logic                 in_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [7:0]           drop_count
);

    localparam int IDX_W = $clog2(2 * CTR_NUMBER + 1);

    tx_state_t                  state;
    tx_state_t                  next_state;
    logic [7:0]                 seq;
    logic [7:0]                 csum;
    logic [IDX_W-1:0]           idx;
    sample_t                    frame;
    sample_t                    sample_in;
    sample_t                    fifo_rd_data;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       pop;
    logic                       accept;
    logic                       last_idx;
    logic [7:0]                 data_byte;

    assign pop      = (state == IDLE) && !fifo_empty;
    assign accept   = tx_valid && tx_ready;
    assign last_idx = (idx == IDX_W'(2 * CTR_NUMBER - 1));
    assign busy     = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        sample_in     = '0;
        sample_in.seq = seq;
        for (int k = 0; k < CTR_NUMBER; k++) begin
            sample_in.words[k] = in_data[k];
        end
    end

    tdc_sample_fifo #(
        .WIDTH ($bits(sample_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr      (in_valid),
        .wr_data (sample_in),
        .rd      (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (!fifo_empty)          next_state = SYNC;
            SYNC:    if (accept)               next_state = SEQ;
            SEQ:     if (accept)               next_state = DATA;
            DATA:    if (accept && last_idx)   next_state = CSUM;
            CSUM:    if (accept)               next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    // Even byte index carries the top 3 bits of a word, odd index the low byte.
    always_comb begin
        data_byte = '0;
        for (int k = 0; k < MAX_CTR_NUMBER; k++) begin
            if (int'(idx) == 2 * k)     data_byte = {5'b0, frame.words[k][CTR_WIDTH-1:8]};
            if (int'(idx) == 2 * k + 1) data_byte = frame.words[k][7:0];
        end
    end

    always_comb begin
        tx_valid = (state != IDLE);
        tx_data  = '0;
        unique case (state)
            SYNC:    tx_data = SYNC_BYTE;
            SEQ:     tx_data = frame.seq;
            DATA:    tx_data = data_byte;
            CSUM:    tx_data = csum;
            default: tx_data = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            seq        <= '0;
            drop_count <= '0;
            frame      <= '0;
            idx        <= '0;
            csum       <= '0;
        end else begin
            if (in_valid) seq <= seq + 8'd1;
            if (in_valid && fifo_full && !pop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (pop) begin
                frame <= fifo_rd_data;
                idx   <= '0;
                csum  <= '0;
            end
            if (accept && ((state == SEQ) || (state == DATA))) csum <= csum + tx_data;
            if (accept && (state == DATA)) idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_tdc_frame_tx.sv
// tb/tb_tdc_frame_tx.sv - scoreboard bench for tdc_frame_tx with one- and three-counter instances
module tb_tdc_frame_tx;
    import tdc_pkg::*;

    localparam int DEPTH = 4;

    typedef logic [7:0] byte_q_t [$];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst;
    logic [10:0] in_data1 [1];
    logic        in_valid1, tx_ready1, tx_valid1, busy1;
    logic [7:0]  tx_data1, drop1;
    logic [10:0] in_data3 [3];
    logic        in_valid3, tx_ready3, tx_valid3, busy3;
    logic [7:0]  tx_data3, drop3;

    tdc_frame_tx #(.CTR_NUMBER(1), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) u_dut1 (
        .clock(clock), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .busy(busy1), .drop_count(drop1));

    tdc_frame_tx #(.CTR_NUMBER(3), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) u_dut3 (
        .clock(clock), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
        .busy(busy3), .drop_count(drop3));

    int checks = 0;
    int passes = 0;
    byte_q_t exp1, exp3;
    int pos1 = 0, pos3 = 0, done1 = 0, done3 = 0, issued1 = 0, issued3 = 0;
    logic [7:0] seq1 = 8'd0, seq3 = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference frame: sync, seq, (high3, low8) per word, then mod-256 sum of everything after sync.
    function automatic byte_q_t make_frame(input logic [7:0] s, input int n, input logic [2:0][10:0] w);
        byte_q_t f;
        int sum;
        f.push_back(8'hA5);
        f.push_back(s);
        sum = int'(s);
        for (int k = 0; k < n; k++) begin
            f.push_back(8'(int'(w[k]) / 256));
            f.push_back(8'(int'(w[k]) % 256));
            sum += int'(w[k]) / 256 + int'(w[k]) % 256;
        end
        f.push_back(8'(sum % 256));
        return f;
    endfunction

    always @(negedge clock) begin
        if (!rst && tx_valid1 && tx_ready1) begin
            if (exp1.size() == 0) begin
                checks++;
                $display("FAIL dut1_extra_byte: got %02h with nothing expected", tx_data1);
            end else begin
                check("dut1_byte", tx_data1, exp1.pop_front());
            end
            pos1++;
            if (pos1 == frame_len(1)) begin pos1 = 0; done1++; end
        end
        if (!rst && tx_valid3 && tx_ready3) begin
            if (exp3.size() == 0) begin
                checks++;
                $display("FAIL dut3_extra_byte: got %02h with nothing expected", tx_data3);
            end else begin
                check("dut3_byte", tx_data3, exp3.pop_front());
            end
            pos3++;
            if (pos3 == frame_len(3)) begin pos3 = 0; done3++; end
        end
    end

    task automatic pulse1(input logic [10:0] w, input bit accept);
        byte_q_t f;
        in_data1[0] = w;
        in_valid1   = 1'b1;
        if (accept) begin
            f = make_frame(seq1, 1, {22'b0, w});
            foreach (f[i]) exp1.push_back(f[i]);
            issued1++;
        end
        seq1++;
        @(posedge clock); #1;
        in_valid1 = 1'b0;
    endtask

    task automatic pulse3(input logic [10:0] w0, input logic [10:0] w1, input logic [10:0] w2);
        byte_q_t f;
        in_data3[0] = w0; in_data3[1] = w1; in_data3[2] = w2;
        in_valid3   = 1'b1;
        f = make_frame(seq3, 3, {w2, w1, w0});
        foreach (f[i]) exp3.push_back(f[i]);
        issued3++;
        seq3++;
        @(posedge clock); #1;
        in_valid3 = 1'b0;
    endtask

    task automatic wait_done1(input int target, input bit rnd);
        int n = 0;
        while (done1 < target && n < 3000) begin
            if (rnd) tx_ready1 = ($urandom % 4) != 0;
            @(posedge clock); #1;
            n++;
        end
        if (done1 < target) begin
            checks++;
            $display("FAIL dut1_wait_timeout: frames done %0d required %0d", done1, target);
        end
        tx_ready1 = 1'b1;
    endtask

    task automatic wait_done3(input int target, input bit rnd);
        int n = 0;
        while (done3 < target && n < 3000) begin
            if (rnd) tx_ready3 = ($urandom % 4) != 0;
            @(posedge clock); #1;
            n++;
        end
        if (done3 < target) begin
            checks++;
            $display("FAIL dut3_wait_timeout: frames done %0d required %0d", done3, target);
        end
        tx_ready3 = 1'b1;
    endtask

    // Only issue when fewer than DEPTH frames are outstanding, so no sample can be dropped.
    task automatic issue1(input bit rnd);
        wait_done1(issued1 - DEPTH + 1, rnd);
        if (rnd) tx_ready1 = ($urandom % 4) != 0;
        pulse1(11'($urandom), 1'b1);
        repeat ($urandom % 3) begin @(posedge clock); #1; end
    endtask

    task automatic issue3(input bit rnd);
        wait_done3(issued3 - DEPTH + 1, rnd);
        if (rnd) tx_ready3 = ($urandom % 4) != 0;
        pulse3(11'($urandom), 11'($urandom), 11'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_ready1 = 1'b0;
        tx_ready3 = 1'b0;
        @(posedge clock); #1;
        exp1.delete(); exp3.delete();
        pos1 = 0; pos3 = 0; done1 = 0; done3 = 0; issued1 = 0; issued3 = 0;
        seq1 = 8'd0; seq3 = 8'd0;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid1 = 1'b0; in_valid3 = 1'b0;
        tx_ready1 = 1'b1; tx_ready3 = 1'b1;
        in_data1[0] = '0;
        in_data3 = '{default: 11'h0};
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;

        check("rst_tx_valid", tx_valid1, 0);
        check("rst_tx_data", tx_data1, 0);
        check("rst_busy", busy1, 0);
        check("rst_drop", drop1, 0);
        check("rst_tx_valid3", tx_valid3, 0);
        check("rst_busy3", busy3, 0);

        pulse1(11'h5A3, 1'b1);
        check("t1_valid_n1", tx_valid1, 0);
        check("t1_busy_n1", busy1, 1);
        @(posedge clock); #1;
        check("t1_valid_n2", tx_valid1, 1);
        check("t1_sync_n2", tx_data1, 8'hA5);
        wait_done1(1, 1'b0);
        check("t1_busy_fall", busy1, 0);

        pulse1(11'h5A3, 1'b1);
        repeat (3) @(posedge clock);
        #1 tx_ready1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", tx_valid1, 1);
            check("t2_hold_data", tx_data1, 8'h05);
            @(posedge clock); #1;
        end
        tx_ready1 = 1'b1;
        wait_done1(2, 1'b0);
        check("t2_busy_fall", busy1, 0);

        do_reset();
        tx_ready1 = 1'b0;
        for (int i = 0; i < 5; i++) pulse1(11'($urandom), 1'b1);
        pulse1(11'($urandom), 1'b0);
        check("t3_drop_count", drop1, 1);
        check("t3_busy", busy1, 1);
        tx_ready1 = 1'b1;
        wait_done1(issued1, 1'b0);
        pulse1(11'h123, 1'b1);
        wait_done1(issued1, 1'b0);
        check("t3_drop_kept", drop1, 1);

        pulse1(11'h2C7, 1'b1);
        repeat (3) @(posedge clock);
        #1 do_reset();
        check("t6_tx_valid", tx_valid1, 0);
        check("t6_busy", busy1, 0);
        check("t6_drop", drop1, 0);
        tx_ready1 = 1'b1;
        tx_ready3 = 1'b1;
        repeat (3) begin @(posedge clock); #1; check("t6_quiet", tx_valid1, 0); end
        pulse1(11'h3E1, 1'b1);
        wait_done1(1, 1'b0);

        for (int i = 0; i < 16; i++) issue3(1'b0);
        pulse3(11'h7FF, 11'h001, 11'h400);
        wait_done3(issued3, 1'b0);
        check("t4_drop3", drop3, 0);

        tx_ready1 = 1'b0;
        for (int i = 0; i < 5; i++) pulse1(11'($urandom), 1'b1);
        tx_ready1 = 1'b1;
        for (int n = 0; n < 50 && tx_valid1; n++) begin @(posedge clock); #1; end
        check("t5_idle_reached", tx_valid1, 0);
        pulse1(11'h0F0, 1'b1);
        check("t5_drop_unchanged", drop1, 0);
        wait_done1(issued1, 1'b0);

        for (int i = 0; i < 257; i++) issue1(1'b0);
        for (int i = 0; i < 100; i++) issue1(1'b1);
        wait_done1(issued1, 1'b1);
        for (int i = 0; i < 30; i++) issue3(1'b1);
        wait_done3(issued3, 1'b1);

        check("end_drop1", drop1, 0);
        check("end_drop3", drop3, 0);
        check("end_queue1", exp1.size(), 0);
        check("end_queue3", exp3.size(), 0);
        check("end_busy1", busy1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
